// File: rtl/frame_buffer_arbiter.sv
// ---------------------------------------------------------------------------
// frame_buffer_arbiter
//
// Purpose:
//   Shares one single-port frame SRAM between a camera capture writer and a
//   display reader. Display reads always take the memory slot. Capture
//   writes are queued in a small FIFO and drain in cycles with no read.
//   Per-frame overflow and drop statistics are kept for the capture side.
//
// Handshake semantics:
//   There is no ready/backpressure anywhere. i_wr_req and i_rd_req are
//   single-cycle request pulses that are always taken in the cycle they are
//   high. A read is never refused. A write is queued, dropped when the FIFO
//   is full, or discarded when its address is out of range. o_rd_valid is a
//   single-cycle pulse qualifying o_rd_data.
//
// Ports:
//   i_clk, i_reset_n          clock, async active-low reset
//   i_frame_start             capture frame start pulse (clears statistics)
//   i_wr_req/address/data     capture write request
//   i_rd_req/address          display read request
//   o_rd_data, o_rd_valid     read return, 3 cycles after i_rd_req
//   o_mem_*                   registered SRAM control/address/data
//   i_mem_rdata               SRAM read data, 1 cycle after o_mem_re
//   o_fifo_level              write FIFO occupancy, 0..FIFO_DEPTH
//   o_wr_overflow             sticky per-frame drop flag
//   o_drop_count              per-frame drop count, saturating
// ---------------------------------------------------------------------------
module frame_buffer_arbiter #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_ADDRESS = 307199
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_frame_start,
  input  logic                          i_wr_req,
  input  logic [ADDR_W-1:0]             i_wr_address,
  input  logic [DATA_W-1:0]             i_wr_data,
  input  logic                          i_rd_req,
  input  logic [ADDR_W-1:0]             i_rd_address,
  output logic [DATA_W-1:0]             o_rd_data,
  output logic                          o_rd_valid,
  output logic [ADDR_W-1:0]             o_mem_address,
  output logic [DATA_W-1:0]             o_mem_wdata,
  output logic                          o_mem_we,
  output logic                          o_mem_re,
  input  logic [DATA_W-1:0]             i_mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_wr_overflow,
  output logic [15:0]                   o_drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0]  FULL_LEVEL = LVL_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] MAX_ADDR   = ADDR_W'(MAX_ADDRESS);

  // Slot state encoding is chosen so each memory strobe is a single state
  // bit: bit0 = read slot, bit1 = write slot. The strobes therefore come
  // straight from flops and can never be high together.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10
  } slot_t;

  slot_t slot_state;

  // Write FIFO storage and pointers
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push_try;
  logic push;
  logic drop;

  // Read return pipeline: o_mem_re -> rd_pending -> o_rd_valid
  logic rd_pending;

  always_comb begin
    fifo_empty = (level == '0);
    fifo_full  = (level == FULL_LEVEL);
    // A write may only take the slot when no read wants it.
    pop        = !i_rd_req && !fifo_empty;
    // Out-of-range pixels vanish without touching the statistics.
    push_try   = i_wr_req && (i_wr_address <= MAX_ADDR);
    // A simultaneous pop frees the slot the new pixel needs.
    drop       = push_try && fifo_full && !pop;
    push       = push_try && !drop;
  end

  // FIFO storage carries no reset; only the pointers define its contents.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= i_wr_address;
      fifo_data[wr_ptr] <= i_wr_data;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally since the depth
  // is a power of two.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Slot FSM: decides every cycle who owns the memory in the next cycle.
  // Address/data hold their previous values in idle slots.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      slot_state    <= S_IDLE;
      o_mem_address <= '0;
      o_mem_wdata   <= '0;
    end else begin
      if (i_rd_req) begin
        slot_state    <= S_RD;
        o_mem_address <= i_rd_address;
      end else if (pop) begin
        slot_state    <= S_WR;
        o_mem_address <= fifo_addr[rd_ptr];
        o_mem_wdata   <= fifo_data[rd_ptr];
      end else begin
        slot_state    <= S_IDLE;
      end
    end
  end

  assign o_mem_re = slot_state[0];
  assign o_mem_we = slot_state[1];

  // Read return: SRAM data is valid the cycle after o_mem_re and is
  // registered once more, giving a fixed 3-cycle request-to-data latency.
  // Reset clears rd_pending so a read in flight never returns.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_pending <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      rd_pending <= o_mem_re;
      o_rd_valid <= rd_pending;
      if (rd_pending) o_rd_data <= i_mem_rdata;
    end
  end

  // Per-frame drop statistics. A drop in the frame-start cycle belongs to
  // the new frame, so it is applied on top of the clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wr_overflow <= 1'b0;
      o_drop_count  <= '0;
    end else if (i_frame_start) begin
      o_wr_overflow <= drop;
      o_drop_count  <= drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      o_wr_overflow <= 1'b1;
      if (o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 16'd1;
    end
  end

  assign o_fifo_level = level;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_frame_buffer_arbiter
//
// Directed scenarios followed by a random phase. A transaction-level model
// (queue of pending pixels, list of pending read returns, drop statistics)
// predicts the memory port and status outputs after every clock edge.
// The SRAM model returns the low 16 address bits one cycle after o_mem_re.
// ---------------------------------------------------------------------------
module tb_frame_buffer_arbiter;

  localparam int ADDR_W      = 19;
  localparam int DATA_W      = 16;
  localparam int FIFO_DEPTH  = 8;
  localparam int MAX_ADDRESS = 307199;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  always #5 i_clk = ~i_clk;

  logic              i_frame_start = 1'b0;
  logic              i_wr_req = 1'b0;
  logic [ADDR_W-1:0] i_wr_address = '0;
  logic [DATA_W-1:0] i_wr_data = '0;
  logic              i_rd_req = 1'b0;
  logic [ADDR_W-1:0] i_rd_address = '0;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_valid;
  logic [ADDR_W-1:0] o_mem_address;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              o_mem_we;
  logic              o_mem_re;
  logic [DATA_W-1:0] i_mem_rdata = '0;
  logic [3:0]        o_fifo_level;
  logic              o_wr_overflow;
  logic [15:0]       o_drop_count;

  frame_buffer_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH), .MAX_ADDRESS(MAX_ADDRESS)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_frame_start(i_frame_start),
    .i_wr_req(i_wr_req), .i_wr_address(i_wr_address), .i_wr_data(i_wr_data),
    .i_rd_req(i_rd_req), .i_rd_address(i_rd_address),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_mem_address(o_mem_address), .o_mem_wdata(o_mem_wdata),
    .o_mem_we(o_mem_we), .o_mem_re(o_mem_re), .i_mem_rdata(i_mem_rdata),
    .o_fifo_level(o_fifo_level), .o_wr_overflow(o_wr_overflow),
    .o_drop_count(o_drop_count)
  );

  // SRAM model: read data = address[15:0], otherwise a marker value.
  always @(posedge i_clk)
    i_mem_rdata <= o_mem_re ? o_mem_address[15:0] : 16'hBAD0;

  // ---------------- reference model ----------------
  logic [ADDR_W+DATA_W-1:0] m_fifo[$];   // pending pixels {addr, data}
  logic [DATA_W-1:0]        exp_q[$];    // expected read return data
  int                       rd_due_q[$]; // step index at which each is due
  logic                     m_we, m_re, m_ovf;
  logic [ADDR_W-1:0]        m_addr;
  logic [DATA_W-1:0]        m_wdata, m_rd_data;
  logic [15:0]              m_drop;
  int                       cur_step;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h (step %0d)", tag, obs, exp, cur_step);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    rd_due_q.delete();
    m_we = 0; m_re = 0; m_ovf = 0;
    m_addr = '0; m_wdata = '0; m_rd_data = '0; m_drop = '0;
  endtask

  task automatic check_all();
    logic exp_valid;
    exp_valid = 1'b0;
    if (rd_due_q.size() > 0 && rd_due_q[0] == cur_step) begin
      exp_valid = 1'b1;
      m_rd_data = exp_q.pop_front();
      void'(rd_due_q.pop_front());
    end
    chk("mem_we",     32'(o_mem_we),      32'(m_we));
    chk("mem_re",     32'(o_mem_re),      32'(m_re));
    chk("mem_address",32'(o_mem_address), 32'(m_addr));
    chk("mem_wdata",  32'(o_mem_wdata),   32'(m_wdata));
    chk("fifo_level", 32'(o_fifo_level),  32'(m_fifo.size()));
    chk("wr_overflow",32'(o_wr_overflow), 32'(m_ovf));
    chk("drop_count", 32'(o_drop_count),  32'(m_drop));
    chk("rd_valid",   32'(o_rd_valid),    32'(exp_valid));
    chk("rd_data",    32'(o_rd_data),     32'(m_rd_data));
  endtask

  // ---------------- driver ----------------
  // One clock cycle: apply inputs, advance the model across the edge, then
  // compare all outputs 1 time unit after the edge.
  task automatic step(input logic rd, input logic [ADDR_W-1:0] rda,
                      input logic wr, input logic [ADDR_W-1:0] wra,
                      input logic [DATA_W-1:0] wrd, input logic fs);
    logic pop, dropped;
    logic [ADDR_W+DATA_W-1:0] head;
    int size_before;
    i_rd_req = rd; i_rd_address = rda;
    i_wr_req = wr; i_wr_address = wra; i_wr_data = wrd;
    i_frame_start = fs;
    @(posedge i_clk);
    size_before = m_fifo.size();
    pop = !rd && (size_before > 0);
    if (rd) begin
      m_re = 1; m_we = 0; m_addr = rda;
      exp_q.push_back(rda[15:0]);
      rd_due_q.push_back(cur_step + 2);
    end else if (pop) begin
      head = m_fifo.pop_front();
      m_we = 1; m_re = 0;
      m_addr = head[ADDR_W+DATA_W-1:DATA_W];
      m_wdata = head[DATA_W-1:0];
    end else begin
      m_we = 0; m_re = 0;
    end
    dropped = 0;
    if (wr && int'(wra) <= MAX_ADDRESS) begin
      if (size_before == FIFO_DEPTH && !pop) dropped = 1;
      else m_fifo.push_back({wra, wrd});
    end
    if (fs) begin
      m_ovf = dropped;
      m_drop = dropped ? 16'd1 : 16'd0;
    end else if (dropped) begin
      m_ovf = 1;
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end
    #1;
    check_all();
    cur_step++;
    i_rd_req = 0; i_wr_req = 0; i_frame_start = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, 0);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 9) == 0)
      return ADDR_W'(MAX_ADDRESS + 1 + $urandom_range(0, 1000));
    return ADDR_W'($urandom_range(0, MAX_ADDRESS));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    cur_step = 0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    check_all();                      // reset state
    i_reset_n = 1'b1;

    // Single pixel write, no reads
    step(0, '0, 1, 19'h00010, 16'hF800, 0);
    idle(3);

    // Reads every 2nd cycle with writes interleaved in free cycles
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) step(1, 19'h12345, 0, '0, '0, 0);
      else            step(0, '0, 1, 19'h00200 + 19'(i), 16'($urandom), 0);
    end
    idle(6);

    // 12 back-to-back reads and writes: 8 queued, 4 dropped, then drain
    step(0, '0, 0, '0, '0, 1);
    for (int i = 0; i < 12; i++)
      step(1, 19'h00400 + 19'(i), 1, 19'h01000 + 19'(i), 16'($urandom), 0);
    idle(12);

    // Address range boundary
    step(0, '0, 1, 19'(MAX_ADDRESS + 1), 16'h1111, 0);
    step(0, '0, 1, 19'(MAX_ADDRESS), 16'h2222, 0);
    idle(4);

    // Frame start coincident with a drop on a full FIFO
    for (int i = 0; i < FIFO_DEPTH; i++)
      step(1, 19'h00800 + 19'(i), 1, 19'h02000 + 19'(i), 16'($urandom), 0);
    step(1, 19'h00900, 1, 19'h03000, 16'hABCD, 1);
    idle(14);

    // Asynchronous reset with 5 queued pixels and reads in flight
    for (int i = 0; i < 5; i++)
      step(1, 19'h00A00 + 19'(i), 1, 19'h04000 + 19'(i), 16'($urandom), 0);
    #2 i_reset_n = 1'b0;
    #1;
    model_reset();
    check_all();                      // outputs cleared without a clock
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    idle(6);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 1) == 1), ADDR_W'($urandom_range(0, MAX_ADDRESS)),
           ($urandom_range(0, 9) < 6), rand_addr(), 16'($urandom),
           ($urandom_range(0, 29) == 0));
    idle(FIFO_DEPTH + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
